// File: rtl/carry_lookahead_adder_16.sv
// Registered 16-bit two-level carry-lookahead adder: {Cout, S} <= X + Y + Cin.
// Four 4-bit CLA blocks feed a second-level lookahead unit; only the result register drives outputs.

module cla_block_4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic [3:0] c,
  output logic       group_g,
  output logic       group_p
);

  // Every in-block carry is a flat sum-of-products from cin, so no ripple exists inside a block.
  assign c[0] = cin;
  assign c[1] = g[0]
              | (p[0] & cin);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign group_g = g[3]
                 | (p[3] & g[2])
                 | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

  assign group_p = p[3] & p[2] & p[1] & p[0];

endmodule

module cla_lookahead_unit (
  input  logic [3:0] grp_g,
  input  logic [3:0] grp_p,
  input  logic       cin,
  output logic       c4,
  output logic       c8,
  output logic       c12,
  output logic       c16
);

  assign c4  = grp_g[0]
             | (grp_p[0] & cin);

  assign c8  = grp_g[1]
             | (grp_p[1] & grp_g[0])
             | (grp_p[1] & grp_p[0] & cin);

  assign c12 = grp_g[2]
             | (grp_p[2] & grp_g[1])
             | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & cin);

  assign c16 = grp_g[3]
             | (grp_p[3] & grp_g[2])
             | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

endmodule

module carry_lookahead_adder_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);

  logic [15:0] bit_g;
  logic [15:0] bit_p;
  logic [15:0] bit_c;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [3:0]  block_cin;
  logic        c4;
  logic        c8;
  logic        c12;
  logic        c16;
  logic [16:0] result_d;
  logic [16:0] result_q;

  assign bit_g = X & Y;
  assign bit_p = X ^ Y;

  // Block carry-ins come only from the second lookahead level, never from a neighbouring block.
  assign block_cin = {c12, c8, c4, Cin};

  for (genvar k = 0; k < 4; k++) begin : g_block
    cla_block_4 u_block (
      .g       (bit_g[4*k +: 4]),
      .p       (bit_p[4*k +: 4]),
      .cin     (block_cin[k]),
      .c       (bit_c[4*k +: 4]),
      .group_g (grp_g[k]),
      .group_p (grp_p[k])
    );
  end

  cla_lookahead_unit u_lookahead (
    .grp_g (grp_g),
    .grp_p (grp_p),
    .cin   (Cin),
    .c4    (c4),
    .c8    (c8),
    .c12   (c12),
    .c16   (c16)
  );

  always_comb begin
    result_d = {c16, bit_p ^ bit_c};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 17'h0_0000;
    end else begin
      result_q <= result_d;
    end
  end

  assign S    = result_q[15:0];
  assign Cout = result_q[16];

endmodule

// File: tb/tb_carry_lookahead_adder_16.sv
// Self-checking bench for carry_lookahead_adder_16: directed corner cases plus
// 1024 random vectors against a plain-arithmetic reference model with one cycle of latency.

module tb_carry_lookahead_adder_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] X;
  logic [15:0] Y;
  logic        Cin;
  logic [15:0] S;
  logic        Cout;

  int n_vectors;
  int n_miscompares;

  carry_lookahead_adder_16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .X     (X),
    .Y     (Y),
    .Cin   (Cin),
    .S     (S),
    .Cout  (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic c);
    model_add = {1'b0, a} + {1'b0, b} + {16'h0000, c};
  endfunction

  // Advance to just after the next rising edge, where outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    X = 16'hFFFF;
    Y = 16'hFFFF;
    Cin = 1'b1;
    #2;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vectors++;
      if (S !== 16'h0000 || Cout !== 1'b0) begin
        n_miscompares++;
        $display("[TB] FAIL reset_hold[%0d]: S=%h Cout=%b, need S=0000 Cout=0", i, S, Cout);
      end
    end
    rst_n = 1'b1;
    step();
    n_vectors++;
    if (S !== 16'hFFFF || Cout !== 1'b1) begin
      n_miscompares++;
      $display("[TB] FAIL reset_release: S=%h Cout=%b, need S=FFFF Cout=1", S, Cout);
    end
  endtask

  task automatic test_directed();
    logic [15:0] tx   [8];
    logic [15:0] ty   [8];
    logic        tc   [8];
    logic [15:0] ts   [8];
    logic        tco  [8];
    tx[0] = 16'h0000; ty[0] = 16'h0000; tc[0] = 1'b0; ts[0] = 16'h0000; tco[0] = 1'b0;
    tx[1] = 16'h1234; ty[1] = 16'h0000; tc[1] = 1'b1; ts[1] = 16'h1235; tco[1] = 1'b0;
    tx[2] = 16'hFFFF; ty[2] = 16'h0000; tc[2] = 1'b1; ts[2] = 16'h0000; tco[2] = 1'b1;
    tx[3] = 16'h00FF; ty[3] = 16'h0001; tc[3] = 1'b0; ts[3] = 16'h0100; tco[3] = 1'b0;
    tx[4] = 16'h0FFF; ty[4] = 16'h0001; tc[4] = 1'b0; ts[4] = 16'h1000; tco[4] = 1'b0;
    tx[5] = 16'h8000; ty[5] = 16'h8000; tc[5] = 1'b0; ts[5] = 16'h0000; tco[5] = 1'b1;
    tx[6] = 16'h7FFF; ty[6] = 16'h7FFF; tc[6] = 1'b1; ts[6] = 16'hFFFF; tco[6] = 1'b0;
    tx[7] = 16'h000F; ty[7] = 16'h0000; tc[7] = 1'b1; ts[7] = 16'h0010; tco[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      X = tx[i];
      Y = ty[i];
      Cin = tc[i];
      step();
      n_vectors++;
      if (S !== ts[i] || Cout !== tco[i]) begin
        n_miscompares++;
        $display("[TB] FAIL directed[%0d] %h+%h+%b: S=%h Cout=%b, need S=%h Cout=%b",
                 i, tx[i], ty[i], tc[i], S, Cout, ts[i], tco[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] prev_exp;
    logic [16:0] exp;
    X = 16'h1111; Y = 16'h2222; Cin = 1'b0;
    step();
    prev_exp = model_add(16'h1111, 16'h2222, 1'b0);
    n_vectors++;
    if ({Cout, S} !== prev_exp) begin
      n_miscompares++;
      $display("[TB] FAIL pipe_first: got %h, need %h", {Cout, S}, prev_exp);
    end
    X = 16'hABCD; Y = 16'h6543; Cin = 1'b1;
    exp = model_add(16'hABCD, 16'h6543, 1'b1);
    #2;
    n_vectors++;
    if ({Cout, S} !== prev_exp) begin
      n_miscompares++;
      $display("[TB] FAIL pipe_hold_before_edge: got %h, need %h", {Cout, S}, prev_exp);
    end
    step();
    n_vectors++;
    if ({Cout, S} !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL pipe_second: got %h, need %h", {Cout, S}, exp);
    end
  endtask

  task automatic test_midstream_reset();
    X = 16'h4321; Y = 16'h1234; Cin = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_vectors++;
    if (S !== 16'h0000 || Cout !== 1'b0) begin
      n_miscompares++;
      $display("[TB] FAIL async_reset: S=%h Cout=%b, need S=0000 Cout=0", S, Cout);
    end
    step();
    n_vectors++;
    if (S !== 16'h0000 || Cout !== 1'b0) begin
      n_miscompares++;
      $display("[TB] FAIL reset_discard: S=%h Cout=%b, need S=0000 Cout=0", S, Cout);
    end
    rst_n = 1'b1;
    X = 16'hF000; Y = 16'h1000; Cin = 1'b0;
    step();
    n_vectors++;
    if (S !== 16'h0000 || Cout !== 1'b1) begin
      n_miscompares++;
      $display("[TB] FAIL post_reset_first: S=%h Cout=%b, need S=0000 Cout=1", S, Cout);
    end
  endtask

  task automatic test_random();
    logic [16:0] exp;
    int          passes;
    passes = 0;
    for (int i = 0; i < 1024; i++) begin
      X = 16'($urandom);
      Y = 16'($urandom);
      Cin = 1'($urandom);
      exp = model_add(X, Y, Cin);
      step();
      n_vectors++;
      if ({Cout, S} !== exp) begin
        n_miscompares++;
        $display("[TB] FAIL random[%0d]: got %h, need %h", i, {Cout, S}, exp);
      end else begin
        passes++;
      end
    end
    $display("[TB] random: %0d of 1024 vectors matched", passes);
  endtask

  initial begin
    n_vectors = 0;
    n_miscompares = 0;
    rst_n = 1'b0;
    X = 16'h0000;
    Y = 16'h0000;
    Cin = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_midstream_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
